// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the DIV/DIVU multi-cycle controller: FSM state
// encoding, handshake levels and the ALU op codes EX uses to launch it.
package div_ctrl_pkg;

  // Controller states; the encoding is visible to EX debug logic, so keep it.
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // Handshake levels as seen by EX.
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // ALU op codes decoded by ID for the two divide flavours.
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // Width of the HI/LO double register bus.
  localparam int DOUBLE_REG_W = 64;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration. The partial remainder is shifted
// left with the next dividend bit, the divisor is trial-subtracted over
// DATA_W+1 bits, and the borrow selects between difference and shifted value.
module div_step
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              bit_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic              q_bit
);

  logic [DATA_W:0] diff;

  // Since rem < divisor, the shifted value is below 2*divisor, so a
  // DATA_W+1 bit subtraction never loses a significant bit; its MSB is the borrow.
  assign diff     = {rem, bit_in} - {1'b0, divisor};
  assign q_bit    = ~diff[DATA_W];
  assign rem_next = q_bit ? diff[DATA_W-1:0] : {rem[DATA_W-2:0], bit_in};

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer beside EX. Operands are latched as magnitudes, divided
// by 32 restoring steps (one per cycle), then sign-fixed into {HI, LO}.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                busy_o
);

  div_state_e          state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rem_r;   // partial remainder
  logic [DATA_W-1:0]   dvd_r;   // dividend bits shifting out, quotient bits shifting in
  logic [DATA_W-1:0]   dvs_r;   // divisor magnitude
  logic                neg_q, neg_r;
  logic [2*DATA_W-1:0] res_r;

  logic                sign1, sign2;
  logic [DATA_W-1:0]   op1_abs, op2_abs;
  logic [DATA_W-1:0]   rem_nxt, q_full, rem_fix, quo_fix;
  logic                q_bit, last;

  // Magnitudes for the signed flavour; -0x80000000 wraps to itself, which is
  // exactly the unsigned magnitude we need.
  assign sign1   = signed_div_i & opdata1_i[DATA_W-1];
  assign sign2   = signed_div_i & opdata2_i[DATA_W-1];
  assign op1_abs = sign1 ? -opdata1_i : opdata1_i;
  assign op2_abs = sign2 ? -opdata2_i : opdata2_i;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem      (rem_r),
    .bit_in   (dvd_r[DATA_W-1]),
    .divisor  (dvs_r),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );

  assign q_full  = {dvd_r[DATA_W-2:0], q_bit};
  assign last    = (cnt == CNT_W'(DATA_W-1));
  assign rem_fix = neg_r ? -rem_nxt : rem_nxt;
  assign quo_fix = neg_q ? -q_full  : q_full;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DIV_FREE;
    else      state <= state_nxt;
  end

  // Next-state logic; a flush overrides everything.
  always_comb begin
    state_nxt = state;
    unique case (state)
      DIV_FREE:    if (start_i) state_nxt = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
      DIV_BY_ZERO: state_nxt = DIV_END;
      DIV_ON:      if (last) state_nxt = DIV_END;
      DIV_END:     if (!start_i) state_nxt = DIV_FREE;
      default:     state_nxt = DIV_FREE;
    endcase
    if (annul_i) state_nxt = DIV_FREE;
  end

  // Operand latch, iteration datapath and final sign fixup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      rem_r <= '0;
      dvd_r <= '0;
      dvs_r <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      res_r <= '0;
    end else if (annul_i) begin
      cnt   <= '0;
      res_r <= '0;
    end else begin
      unique case (state)
        DIV_FREE: begin
          if (start_i) begin
            cnt   <= '0;
            rem_r <= '0;
            dvd_r <= op1_abs;
            dvs_r <= op2_abs;
            neg_q <= sign1 ^ sign2;
            neg_r <= sign1;
            res_r <= '0;
          end
        end
        DIV_BY_ZERO: res_r <= '0;
        DIV_ON: begin
          rem_r <= rem_nxt;
          dvd_r <= q_full;
          cnt   <= cnt + 1'b1;
          if (last) begin
            cnt   <= '0;
            res_r <= {rem_fix, quo_fix};
          end
        end
        default: ;
      endcase
    end
  end

  // The result is only presented while it is valid.
  assign ready_o  = (state == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
  assign busy_o   = (state == DIV_ON) || (state == DIV_BY_ZERO);
  assign result_o = (state == DIV_END) ? res_r : '0;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: table of divide vectors plus random ones checked
// against a behavioural model through a scoreboard queue, and hand-written
// sequences for flush and asynchronous reset in the middle of a divide.
module tb_div_ctrl;

  typedef struct {
    logic        sgn;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;

  logic        clk, rst, start, annul, sgn;
  logic [31:0] a, b;
  logic [63:0] result;
  logic        ready, busy;

  int   checks = 0;
  int   failures = 0;
  vec_t sb[$];
  vec_t tbl[12];

  div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .annul_i      (annul),
    .signed_div_i (sgn),
    .opdata1_i    (a),
    .opdata2_i    (b),
    .result_o     (result),
    .ready_o      (ready),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] hi, input logic [31:0] lo, input int lat);
    vec_t v;
    v.sgn = s; v.a = x; v.b = y; v.hi = hi; v.lo = lo; v.lat = lat;
    return v;
  endfunction

  // Reference model for random vectors (callers avoid /0 and signed overflow).
  function automatic vec_t model(input logic s, input logic [31:0] x, input logic [31:0] y);
    vec_t v;
    v = mk(s, x, y, 32'h0, 32'h0, 33);
    if (s) begin
      v.lo = $signed(x) / $signed(y);
      v.hi = $signed(x) % $signed(y);
    end else begin
      v.lo = x / y;
      v.hi = x % y;
    end
    return v;
  endfunction

  // Issue one divide, hold start through END, then release it.
  task automatic run_div(input string nm, input vec_t v);
    vec_t e;
    int   n, nb;
    bit   got;
    @(posedge clk); #1;
    start = 1'b1; sgn = v.sgn; a = v.a; b = v.b;
    sb.push_back(v);
    n = 0; nb = 0; got = 0;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (busy) nb++;
      if (ready) got = 1;
      // Operands must be ignored once the divide is under way.
      if (n == 1) begin a = $urandom; b = $urandom; sgn = ~sgn; end
    end
    e = sb.pop_front();
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s timeout waiting for ready_o after %0d edges", nm, n);
    end else begin
      check({nm, " result"}, {2'b0, result}, {2'b0, e.hi, e.lo});
      check({nm, " latency"}, 66'(n), 66'(e.lat));
      check({nm, " busy_cycles"}, 66'(nb), 66'(e.lat - 1));
      @(posedge clk); #1;
      check({nm, " hold"}, {1'b0, ready, result}, {1'b0, 1'b1, e.hi, e.lo});
    end
    start = 1'b0;
    @(posedge clk); #1;
    check({nm, " free"}, {busy, ready, result}, 66'h0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; annul = 1'b0; sgn = 1'b0; a = '0; b = '0;

    tbl[0]  = mk(1'b0, 32'd100,        32'd7,          32'h2,        32'hE,        33);
    tbl[1]  = mk(1'b1, 32'hFFFF_FFF9,  32'h2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    tbl[2]  = mk(1'b1, 32'd5,          32'd0,          32'h0,        32'h0,        2);
    tbl[3]  = mk(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,        32'h8000_0000, 33);
    tbl[4]  = mk(1'b0, 32'hFFFF_FFFF,  32'h10,         32'hF,        32'h0FFF_FFFF, 33);
    tbl[5]  = mk(1'b1, 32'd7,          32'hFFFF_FFFE,  32'h1,        32'hFFFF_FFFD, 33);
    tbl[6]  = mk(1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF, 32'h3,        33);
    tbl[7]  = mk(1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFF2, 33);
    tbl[8]  = mk(1'b0, 32'd7,          32'd100,        32'h7,        32'h0,        33);
    tbl[9]  = mk(1'b0, 32'hFFFF_FFFF,  32'h0,          32'h0,        32'h0,        2);
    tbl[10] = mk(1'b0, 32'hFFFF_FFFF,  32'h1,          32'h0,        32'hFFFF_FFFF, 33);
    tbl[11] = mk(1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 32'h0,        33);

    // Reset state.
    #12;
    check("reset_outputs", {busy, ready, result}, 66'h0);
    #3 rst = 1'b1;

    for (int i = 0; i < 12; i++) run_div($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 6; i++) begin
      logic        s;
      logic [31:0] x, y;
      s = 1'($urandom_range(0, 1));
      x = $urandom;
      y = ($urandom >> $urandom_range(0, 28)) | 32'h1;
      if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) y = 32'h3;
      run_div($sformatf("rand%0d", i), model(s, x, y));
    end

    // Flush on the 10th ON cycle: no result may ever appear.
    begin
      int rdy_seen = 0;
      @(posedge clk); #1;
      start = 1'b1; sgn = 1'b0; a = 32'd9; b = 32'd3;
      repeat (10) @(posedge clk);
      #1 check("annul_busy_before", {65'h0, busy}, 66'h1);
      annul = 1'b1;
      @(posedge clk); #1;
      annul = 1'b0; start = 1'b0;
      check("annul_free", {busy, ready, result}, 66'h0);
      repeat (40) begin
        @(posedge clk); #1;
        if (ready) rdy_seen++;
      end
      check("annul_no_ready", 66'(rdy_seen), 66'h0);
    end
    run_div("annul_restart", mk(1'b0, 32'd9, 32'd3, 32'h0, 32'h3, 33));

    // Asynchronous reset mid-divide, between clock edges.
    @(posedge clk); #1;
    start = 1'b1; sgn = 1'b0; a = 32'd123456; b = 32'd7;
    repeat (20) @(posedge clk);
    #3 rst = 1'b0;
    #1 check("async_rst_outputs", {busy, ready, result}, 66'h0);
    start = 1'b0;
    @(posedge clk); #4 rst = 1'b1;
    begin
      int stale = 0;
      repeat (5) begin
        @(posedge clk); #1;
        if (ready || busy || result != 64'h0) stale++;
      end
      check("post_rst_quiet", 66'(stale), 66'h0);
    end
    run_div("post_rst_div", mk(1'b0, 32'd1000, 32'd10, 32'h0, 32'd100, 33));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
